pop_fitness_dispatch: RTL

- Host-side driver and collector for fitness_eval.
- On start, it pushes the energy configuration into fitness_eval (Set_data cycle).
- It then streams all POP_SIZE individuals from the population RAM, one per cycle, and collects the returned energies by index.
- Each energy is written to a fitness RAM, the minimum-energy individual is tracked, and done is pulsed when every result has returned.

---
 rtl/fitness_pkg.sv | 29 ++
 rtl/fit_best_tracker.sv | 55 +++++
 rtl/pop_fitness_dispatch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fitness_pkg.sv
// Shared widths and FSM encoding for the fitness dispatch slice.
// Nothing here is synthesised on its own; the top and its sub-module import it.
package fitness_pkg;

  localparam int NUM_PARTICLE_TYPE        = 3;
  localparam int DATA_WIDTH               = 4;
  localparam int PARTICLE_LENGTH          = 2;
  localparam int LATTICE_LENGTH           = 11;
  localparam int SELF_FIT_LENGTH          = 10;
  localparam int SELF_ENERGY_VEC_LENGTH   = NUM_PARTICLE_TYPE * DATA_WIDTH;
  localparam int INTERATION_MATRIX_LENGTH = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
  localparam int INDIVIDUAL_LENGTH        = LATTICE_LENGTH * PARTICLE_LENGTH;
  localparam int POP_SIZE                 = 50;
  localparam int IDX_WIDTH                = $clog2(POP_SIZE);
  // The result counter must be able to hold POP_SIZE itself.
  localparam int CNT_WIDTH                = $clog2(POP_SIZE + 1);

  // POP_SIZE at one bit wider than an index, for range checks on returned indices.
  localparam logic [IDX_WIDTH:0] POP_LIMIT = (IDX_WIDTH + 1)'(POP_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } disp_state_e;

endpackage

// File: rtl/fit_best_tracker.sv
// Fitness RAM write register plus running-minimum tracker.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   clear_i         start of a new generation: best back to all-ones / index 0
//   res_valid_i     a result is being collected this cycle
//   res_energy_i    returned energy
//   res_idx_i       returned individual index (out-of-range indices are dropped)
//   fit_we_o/fit_addr_o/fit_wdata_o   registered fitness RAM write
//   best_energy_o/best_idx_o          minimum so far in this generation
module fit_best_tracker
  import fitness_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       res_valid_i,
  input  logic [SELF_FIT_LENGTH-1:0] res_energy_i,
  input  logic [IDX_WIDTH-1:0]       res_idx_i,
  output logic                       fit_we_o,
  output logic [IDX_WIDTH-1:0]       fit_addr_o,
  output logic [SELF_FIT_LENGTH-1:0] fit_wdata_o,
  output logic [SELF_FIT_LENGTH-1:0] best_energy_o,
  output logic [IDX_WIDTH-1:0]       best_idx_o
);

  logic idx_in_range;

  assign idx_in_range = {1'b0, res_idx_i} < POP_LIMIT;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fit_we_o      <= 1'b0;
      fit_addr_o    <= '0;
      fit_wdata_o   <= '0;
      best_energy_o <= '1;
      best_idx_o    <= '0;
    end else begin
      fit_we_o <= 1'b0;
      if (clear_i) begin
        best_energy_o <= '1;
        best_idx_o    <= '0;
      end else if (res_valid_i && idx_in_range) begin
        fit_we_o    <= 1'b1;
        fit_addr_o  <= res_idx_i;
        fit_wdata_o <= res_energy_i;
        // Strict compare: on a tie the earlier result keeps the title.
        if (res_energy_i < best_energy_o) begin
          best_energy_o <= res_energy_i;
          best_idx_o    <= res_idx_i;
        end
      end
    end
  end

endmodule

// File: rtl/pop_fitness_dispatch.sv
// Host-side driver/collector for fitness_eval: configures it, streams the
// whole population from the population RAM, writes returned energies into
// the fitness RAM and tracks the minimum-energy individual.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   start_i                            evaluate one generation (accepted in IDLE only)
//   self_energy_vec_i/interact_matrix_i configuration, sampled on accepted start
//   pop_rd_*                           population RAM read port (1-cycle latency)
//   fe_*_o / fe_*_i                    fitness_eval request / result interface
//   fit_*                              fitness RAM write port
//   best_energy_o/best_idx_o           generation minimum
//   busy_o, done_o                     status
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start_i
// ST_CFG   | Set_data cycle: latched configuration pushed to fitness_eval
// ST_ISSUE | one population read per cycle, addresses 0..POP_SIZE-1
// ST_DRAIN | all issued; waiting for the remaining results
// ST_DONE  | done_o pulse, back to idle
module pop_fitness_dispatch
  import fitness_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [SELF_ENERGY_VEC_LENGTH-1:0]   self_energy_vec_i,
  input  logic [INTERATION_MATRIX_LENGTH-1:0] interact_matrix_i,
  output logic                                pop_rd_en_o,
  output logic [IDX_WIDTH-1:0]                pop_rd_addr_o,
  input  logic [INDIVIDUAL_LENGTH-1:0]        pop_rd_data_i,
  output logic                                fe_set_data_o,
  output logic [SELF_ENERGY_VEC_LENGTH-1:0]   fe_self_energy_vec_o,
  output logic [INTERATION_MATRIX_LENGTH-1:0] fe_interact_matrix_o,
  output logic                                fe_in_valid_o,
  output logic [INDIVIDUAL_LENGTH-1:0]        fe_individual_vec_o,
  output logic [IDX_WIDTH-1:0]                fe_ind_idx_o,
  input  logic                                fe_out_valid_i,
  input  logic [SELF_FIT_LENGTH-1:0]          fe_total_energy_i,
  input  logic [IDX_WIDTH-1:0]                fe_ind_wb_idx_i,
  output logic                                fit_we_o,
  output logic [IDX_WIDTH-1:0]                fit_addr_o,
  output logic [SELF_FIT_LENGTH-1:0]          fit_wdata_o,
  output logic [SELF_FIT_LENGTH-1:0]          best_energy_o,
  output logic [IDX_WIDTH-1:0]                best_idx_o,
  output logic                                busy_o,
  output logic                                done_o
);

  disp_state_e          state_q;
  logic [CNT_WIDTH-1:0] remain_q;   // results still outstanding, counts down
  logic                 collect;
  logic                 res_take;
  logic                 start_take;

  assign collect    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign res_take   = collect && fe_out_valid_i;
  assign start_take = (state_q == ST_IDLE) && start_i;

  // RAM read data arrives in the cycle fe_in_valid_o is high, so it is
  // forwarded directly rather than re-registered; gated so it reads 0 when idle.
  assign fe_individual_vec_o = fe_in_valid_o ? pop_rd_data_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q              <= ST_IDLE;
      remain_q             <= '0;
      pop_rd_en_o          <= 1'b0;
      pop_rd_addr_o        <= '0;
      fe_set_data_o        <= 1'b0;
      fe_self_energy_vec_o <= '0;
      fe_interact_matrix_o <= '0;
      fe_in_valid_o        <= 1'b0;
      fe_ind_idx_o         <= '0;
      busy_o               <= 1'b0;
      done_o               <= 1'b0;
    end else begin
      fe_set_data_o <= 1'b0;
      done_o        <= 1'b0;
      // Index travels one cycle behind the read, alongside the read data.
      fe_in_valid_o <= pop_rd_en_o;
      fe_ind_idx_o  <= pop_rd_addr_o;

      // Out-of-range indices are still counted; only the write is dropped.
      if (res_take && (remain_q != '0))
        remain_q <= remain_q - 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            fe_self_energy_vec_o <= self_energy_vec_i;
            fe_interact_matrix_o <= interact_matrix_i;
            fe_set_data_o        <= 1'b1;
            remain_q             <= CNT_WIDTH'(POP_SIZE);
            busy_o               <= 1'b1;
            state_q              <= ST_CFG;
          end
        end
        ST_CFG: begin
          pop_rd_en_o   <= 1'b1;
          pop_rd_addr_o <= '0;
          state_q       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (pop_rd_addr_o == IDX_WIDTH'(POP_SIZE - 1)) begin
            pop_rd_en_o <= 1'b0;
            state_q     <= ST_DRAIN;
          end else begin
            pop_rd_addr_o <= pop_rd_addr_o + 1'b1;
          end
        end
        ST_DRAIN: begin
          // The last result's write is visible in the same cycle the count hits 0.
          if (remain_q == '0) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fit_best_tracker u_best (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (start_take),
    .res_valid_i   (res_take),
    .res_energy_i  (fe_total_energy_i),
    .res_idx_i     (fe_ind_wb_idx_i),
    .fit_we_o      (fit_we_o),
    .fit_addr_o    (fit_addr_o),
    .fit_wdata_o   (fit_wdata_o),
    .best_energy_o (best_energy_o),
    .best_idx_o    (best_idx_o)
  );

endmodule
